// File: rtl/aes_subbytes_seq.sv
// Multi-cycle AES SubBytes/InvSubBytes: LANES shared S-boxes walk the 128-bit state.
// Optional macro SUBBYTES_OUT_REG_EN adds one output register stage (latency NCYC+1).
module aes_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] sb
);
    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
`ifdef SUBBYTES_OUT_REG_EN
    localparam logic [1:0] S_FLUSH = 2'd2;
`endif

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    logic [1:0]         fsm_reg;
    logic [CW-1:0]      cnt_reg;
    logic [127:0]       work_reg;
    logic               dec_reg;
    logic [127:0]       sb_reg;
    logic               done_reg;
    logic               busy_reg;
    logic [8*LANES-1:0] subbed;
    logic [127:0]       work_next;
`ifdef SUBBYTES_OUT_REG_EN
    logic [127:0]       pipe_reg;
`endif

    // The lanes always read the top bytes; the work register rotates so that
    // after NCYC passes every byte is substituted and back in its original slot.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_in;
            assign lane_in = work_reg[127-8*gi -: 8];
            assign subbed[8*(LANES-1-gi) +: 8] = dec_reg ? sbox_inv(lane_in) : sbox_fwd(lane_in);
        end
        if (LANES == 16) begin : g_full
            assign work_next = subbed;
        end else begin : g_rot
            assign work_next = {work_reg[127-8*LANES:0], subbed};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg  <= S_IDLE;
            cnt_reg  <= '0;
            work_reg <= '0;
            dec_reg  <= 1'b0;
            sb_reg   <= '0;
            done_reg <= 1'b0;
            busy_reg <= 1'b0;
`ifdef SUBBYTES_OUT_REG_EN
            pipe_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                S_IDLE: begin
                    if (start) begin
                        work_reg <= state_in;
                        dec_reg  <= decrypt;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        fsm_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    work_reg <= work_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
`ifdef SUBBYTES_OUT_REG_EN
                        pipe_reg <= work_next;
                        fsm_reg  <= S_FLUSH;
`else
                        sb_reg   <= work_next;
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                        fsm_reg  <= S_IDLE;
`endif
                    end
                end
`ifdef SUBBYTES_OUT_REG_EN
                S_FLUSH: begin
                    sb_reg   <= pipe_reg;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    fsm_reg  <= S_IDLE;
                end
`endif
                default: fsm_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sb   = sb_reg;
endmodule
